// File: rtl/drops_pkg.sv
// drops_pkg -- shared definitions for the falling-drop game stage.
//   GS         default matrix edge length
//   LFSR_W     LFSR width
//   LFSR_TAPS  feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of a left-shifting register)
//   state_t    FSM encoding: IDLE=0, RUN=1, OVER=2
//   row_lsb()  bit index of column 0 of a given row in the flattened frame
package drops_pkg;

  localparam int GS     = 8;
  localparam int LFSR_W = 8;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Row r of a gs*gs frame occupies bits [gs*r +: gs]; row 0 is the top row.
  function automatic int row_lsb(input int gs, input int r);
    return gs * r;
  endfunction

endpackage

// File: rtl/drop_lfsr.sv
// drop_lfsr -- free-running 8-bit Fibonacci LFSR used as the drop spawner.
//   clk    in   clock
//   rst_n  in   asynchronous reset, active low (loads SEED)
//   value  out  current register contents
// SEED must be nonzero, otherwise the register locks at zero.
module drop_lfsr
  import drops_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] value
);

  logic fb;

  // XOR of the tapped stages is shifted into bit 0.
  assign fb = ^(value & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= SEED;
    else        value <= {value[LFSR_W-2:0], fb};
  end

endmodule

// File: rtl/drop_field.sv
// drop_field -- game-state stage in front of the 8x8 display scanner.
// Keeps the falling-drop field, spawns drops from an LFSR, scores catches against
// the player column and presents a frame that only changes on scanner end-of-frame.
//   clk_i         in   system clock
//   rst_ni        in   asynchronous reset, active low
//   en_i          in   run request; low returns to IDLE
//   player_col_i  in   catcher column in the bottom row
//   d_disp_i      in   scanner end-of-frame pulse (frame sync)
//   matrix_o      out  frame, bit gs*r+c = row r / col c, row 0 on top
//   e_disp_o      out  scanner enable (high in RUN and OVER)
//   score_o       out  catch count, saturating at 255
//   miss_o        out  one-cycle pulse per missed drop
//   over_o        out  game-over flag
// Build option: DROP_FIELD_BLINK_EN -- when defined, the frame blinks all-ones /
// frozen image every TICK_DIV frames while in OVER; otherwise OVER is static.
module drop_field
  import drops_pkg::*;
#(
  parameter int          gs        = GS,
  parameter int          TICK_DIV  = 16,
  parameter int          MAX_MISS  = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [$clog2(gs)-1:0] player_col_i,
  input  logic                  d_disp_i,
  output logic [gs*gs-1:0]      matrix_o,
  output logic                  e_disp_o,
  output logic [7:0]            score_o,
  output logic                  miss_o,
  output logic                  over_o
);

  localparam int CW = $clog2(gs);
  localparam int FW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = 4;
  localparam int LAST = gs - 1;

  state_t state, state_nxt;

  logic [gs-1:0][gs-1:0] field, field_nxt, frame_img, shadow;
  logic [FW-1:0]         frm_cnt;
  logic [MW-1:0]         miss_cnt;
  logic [LFSR_W-1:0]     lfsr;
  logic                  blink;

  logic          disp, wrap, step, player_ok, hit, miss, last_miss;
  logic [gs-1:0] bottom, spawn, player_row;
  logic          unused_lfsr;

  drop_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .value (lfsr)
  );

  // Only the top bit and the low column bits drive spawning.
  assign unused_lfsr = ^lfsr;

  // ---------------------------------------------------------------------------
  // Frame sync and game step
  // ---------------------------------------------------------------------------
  // A scanner pulse only counts once the scanner has actually been enabled, so a
  // pulse on the IDLE->RUN edge (or any partial frame before it) is dropped.
  assign disp = d_disp_i & e_disp_o;
  assign wrap = (frm_cnt == FW'(TICK_DIV - 1));
  assign step = en_i & (state == ST_RUN) & disp & wrap;

  // Out-of-range columns neither draw the catcher nor score.
  assign player_ok  = ({1'b0, player_col_i} < (CW+1)'(gs));
  assign player_row = player_ok ? (gs'(1) << player_col_i) : '0;

  assign bottom    = field[LAST];
  assign hit       = step & player_ok & bottom[player_col_i];
  assign miss      = step & (|bottom) & ~hit;
  assign last_miss = miss & (miss_cnt == MW'(MAX_MISS - 1));

  // New drops appear in row 0 about half the time (LFSR MSB), column from low bits.
  assign spawn = lfsr[LFSR_W-1] ? (gs'(1) << lfsr[CW-1:0]) : '0;

  always_comb begin
    field_nxt = field;
    if (step) begin
      for (int r = LAST; r >= 1; r--) field_nxt[r] = field[r-1];
      field_nxt[0] = spawn;
    end
  end

  // Image loaded into the shadow: post-step field with the catcher overlaid.
  always_comb begin
    frame_img       = field_nxt;
    frame_img[LAST] = field_nxt[LAST] | player_row;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!en_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_RUN;
        ST_RUN:  if (last_miss) state_nxt = ST_OVER;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      e_disp_o <= 1'b0;
      field    <= '0;
      shadow   <= '0;
      frm_cnt  <= '0;
      miss_cnt <= '0;
      score_o  <= '0;
      miss_o   <= 1'b0;
      over_o   <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state    <= state_nxt;
      e_disp_o <= (state_nxt != ST_IDLE);
      miss_o   <= miss;

      if (state_nxt == ST_IDLE) begin
        // Leaving or staying idle: blank the display, keep score/over for readout.
        field  <= '0;
        shadow <= '0;
        blink  <= 1'b0;
      end else if (state == ST_IDLE) begin
        // Fresh game.
        field    <= '0;
        shadow   <= '0;
        blink    <= 1'b0;
        frm_cnt  <= '0;
        miss_cnt <= '0;
        score_o  <= '0;
        over_o   <= 1'b0;
      end else begin
        field <= field_nxt;

        if (disp) frm_cnt <= wrap ? '0 : frm_cnt + 1'b1;

        // Shadow only moves at frame boundaries so a scan never tears; in OVER
        // it stays on the last RUN frame.
        if ((state == ST_RUN) && disp) shadow <= frame_img;

        if (hit && (score_o != 8'hFF)) score_o <= score_o + 8'd1;
        if (miss) miss_cnt <= miss_cnt + 1'b1;
        if (state_nxt == ST_OVER) over_o <= 1'b1;

`ifdef DROP_FIELD_BLINK_EN
        if ((state == ST_OVER) && disp && wrap) blink <= ~blink;
`endif
      end
    end
  end

  assign matrix_o = blink ? '1 : shadow;

endmodule

// File: tb/tb_drop_field.sv
module tb_drop_field;

  localparam int GS = 8;
  localparam int TD = 2;
  localparam int MM = 3;
  localparam int ST_I = 0, ST_R = 1, ST_O = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        d = 1'b0;
  logic [2:0]  pcol = 3'd0;
  logic [63:0] matrix;
  logic        e_disp, miss, over;
  logic [7:0]  score;

  int n_tests = 0;
  int n_fail  = 0;

  drop_field #(.gs(GS), .TICK_DIV(TD), .MAX_MISS(MM), .LFSR_SEED(8'hA5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .player_col_i (pcol),
    .d_disp_i     (d),
    .matrix_o     (matrix),
    .e_disp_o     (e_disp),
    .score_o      (score),
    .miss_o       (miss),
    .over_o       (over)
  );

  always #5 clk = ~clk;

  // Reference model: drops as a column per row (-1 = empty), plain counters.
  int          m_st;
  logic [7:0]  m_lfsr;
  int          m_drops[GS];
  int          m_cnt, m_score, m_misses, m_hits;
  bit          m_edisp, m_miss, m_over, m_blink;
  logic [63:0] m_shadow;

  function automatic logic [63:0] exp_matrix();
    logic [63:0] ones;
    ones = '1;
    return m_blink ? ones : m_shadow;
  endfunction

  task automatic m_reset();
    m_st = ST_I; m_lfsr = 8'hA5; m_cnt = 0; m_score = 0; m_misses = 0;
    m_edisp = 0; m_miss = 0; m_over = 0; m_blink = 0; m_shadow = '0;
    foreach (m_drops[r]) m_drops[r] = -1;
  endtask

  task automatic m_render(input int pc);
    m_shadow = '0;
    for (int r = 0; r < GS; r++)
      if (m_drops[r] >= 0) m_shadow[GS*r + m_drops[r]] = 1'b1;
    m_shadow[GS*(GS-1) + pc] = 1'b1;
  endtask

  task automatic m_step(input int pc);
    int b;
    b = m_drops[GS-1];
    if (b >= 0) begin
      if (b == pc) begin
        m_hits++;
        if (m_score < 255) m_score++;
      end else begin
        m_misses++;
        m_miss = 1;
        if (m_misses == MM) begin m_st = ST_O; m_over = 1; end
      end
    end
    for (int r = GS-1; r >= 1; r--) m_drops[r] = m_drops[r-1];
    m_drops[0] = m_lfsr[7] ? int'(m_lfsr[2:0]) : -1;
  endtask

  task automatic m_edge(input bit e, input int pc, input bit dd);
    logic [7:0] nl;
    bit disp, wrap;
    nl = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    disp = dd && m_edisp;
    m_miss = 0;
    if (!e) begin
      m_st = ST_I; m_shadow = '0; m_blink = 0;
      foreach (m_drops[r]) m_drops[r] = -1;
    end else if (m_st == ST_I) begin
      m_st = ST_R; m_shadow = '0; m_blink = 0; m_score = 0; m_misses = 0;
      m_cnt = 0; m_over = 0;
      foreach (m_drops[r]) m_drops[r] = -1;
    end else if (disp) begin
      wrap = (m_cnt == TD-1);
      m_cnt = wrap ? 0 : m_cnt + 1;
      if (m_st == ST_R) begin
        if (wrap) m_step(pc);
        m_render(pc);
      end else begin
`ifdef DROP_FIELD_BLINK_EN
        if (wrap) m_blink = !m_blink;
`endif
      end
    end
    m_edisp = (m_st != ST_I);
    m_lfsr  = nl;
  endtask

  task automatic tick(input bit e, input int pc, input bit dd);
    en = e; pcol = 3'(pc); d = dd;
    @(posedge clk);
    m_edge(e, pc, dd);
    #1;
    d = 1'b0;
  endtask

  task automatic restart();
    tick(0, 0, 0);
    tick(1, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; d = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    n_tests++;
    if ({matrix, e_disp, score, miss, over} !== '0) begin
      n_fail++; $display("FAIL reset_state: got matrix=%h e=%b score=%0d miss=%b over=%b, want all 0",
                         matrix, e_disp, score, miss, over);
    end
    for (int i = 0; i < 12; i++) tick(1, 3, (i % 3) == 2);
    n_tests++;
    if (e_disp !== 1'b1) begin n_fail++; $display("FAIL reset_prerun_edisp: got %b want 1", e_disp); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({matrix, e_disp, score, miss, over} !== '0) begin
      n_fail++; $display("FAIL reset_async: got matrix=%h e=%b score=%0d, want all 0 without clock",
                         matrix, e_disp, score);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  // Pulses every 8 cycles; spawn pattern depends on the LFSR starting at A5.
  task automatic test_sync();
    logic [63:0] prev;
    int pc;
    tick(1, 0, 0);
    prev = matrix;
    for (int i = 0; i < 240; i++) begin
      pc = $urandom_range(7);
      tick(1, pc, (i % 8) == 7);
      n_tests++;
      if (matrix !== exp_matrix()) begin
        n_fail++; $display("FAIL sync_matrix[%0d]: got %h want %h", i, matrix, exp_matrix());
      end
      if ((i % 8) != 7) begin
        n_tests++;
        if (matrix !== prev) begin
          n_fail++; $display("FAIL sync_tear[%0d]: got %h want unchanged %h", i, matrix, prev);
        end
      end
      prev = matrix;
    end
  endtask

  // Catcher follows the drop in the bottom row until 300 catches.
  task automatic test_catch();
    int pc;
    restart();
    n_tests++;
    if (score !== 8'd0) begin n_fail++; $display("FAIL catch_start_score: got %0d want 0", score); end
    m_hits = 0;
    for (int i = 0; i < 12000 && m_hits < 300; i++) begin
      pc = (m_drops[GS-1] >= 0) ? m_drops[GS-1] : int'($urandom_range(7));
      tick(1, pc, (i % 2) == 1);
      n_tests++;
      if (score !== 8'(m_score) || miss !== 1'b0) begin
        n_fail++; $display("FAIL catch_score[%0d]: got score=%0d miss=%b want score=%0d miss=0",
                           i, score, miss, m_score);
      end
    end
    n_tests++;
    if (score !== 8'd255 || m_hits < 300) begin
      n_fail++; $display("FAIL catch_saturate: got score=%0d after %0d catches want 255 after 300", score, m_hits);
    end
  endtask

  task automatic test_abort();
    logic [7:0] held;
    held = score;
    tick(1, 1, 0);
    tick(1, 1, 1);
    tick(1, 1, 0);
    tick(0, 1, 0);
    n_tests++;
    if (e_disp !== 1'b0 || matrix !== '0) begin
      n_fail++; $display("FAIL abort_blank: got e=%b matrix=%h want e=0 matrix=0", e_disp, matrix);
    end
    n_tests++;
    if (score !== held) begin n_fail++; $display("FAIL abort_hold: got score=%0d want %0d", score, held); end
    tick(1, 1, 1);
    n_tests++;
    if (e_disp !== 1'b1 || score !== 8'd0 || over !== 1'b0 || matrix !== '0) begin
      n_fail++; $display("FAIL abort_reenable: got e=%b score=%0d over=%b matrix=%h want 1/0/0/0",
                         e_disp, score, over, matrix);
    end
    for (int i = 0; i < 16; i++) begin
      tick(1, 1, (i % 2) == 1);
      n_tests++;
      if (matrix !== exp_matrix()) begin
        n_fail++; $display("FAIL abort_run[%0d]: got %h want %h", i, matrix, exp_matrix());
      end
    end
  endtask

  // Catcher dodges every drop: MM misses end the game, then the frame freezes.
  task automatic test_miss_over();
    int pc, pulses;
    logic [63:0] frozen;
    restart();
    pulses = 0;
    for (int i = 0; i < 2000 && m_st != ST_O; i++) begin
      pc = (m_drops[GS-1] >= 0) ? (m_drops[GS-1] + 1) % GS : int'($urandom_range(7));
      tick(1, pc, (i % 2) == 1);
      if (miss === 1'b1) pulses++;
      n_tests++;
      if (miss !== m_miss || over !== m_over || matrix !== exp_matrix()) begin
        n_fail++; $display("FAIL miss_track[%0d]: got miss=%b over=%b matrix=%h want %b %b %h",
                           i, miss, over, matrix, m_miss, m_over, exp_matrix());
      end
    end
    tick(1, 0, 0);
    if (miss === 1'b1) pulses++;
    n_tests++;
    if (pulses != MM || over !== 1'b1 || e_disp !== 1'b1) begin
      n_fail++; $display("FAIL miss_over: got pulses=%0d over=%b e=%b want %0d 1 1", pulses, over, e_disp, MM);
    end
    frozen = m_shadow;
    for (int i = 0; i < 24; i++) begin
      tick(1, $urandom_range(7), (i % 2) == 1);
      n_tests++;
      if (matrix !== exp_matrix() || miss !== 1'b0) begin
        n_fail++; $display("FAIL over_frame[%0d]: got %h miss=%b want %h miss=0", i, matrix, miss, exp_matrix());
      end
`ifndef DROP_FIELD_BLINK_EN
      n_tests++;
      if (matrix !== frozen) begin
        n_fail++; $display("FAIL over_static[%0d]: got %h want %h", i, matrix, frozen);
      end
`endif
    end
    tick(0, 0, 0);
    n_tests++;
    if (over !== 1'b1 || matrix !== '0 || e_disp !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold_over: got over=%b matrix=%h e=%b want 1 0 0", over, matrix, e_disp);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_sync();
    test_catch();
    test_abort();
    test_miss_over();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
